// File: rtl/l1vc_pkg.sv
// Shared types and default geometry for the L1 victim-cache requester.
package l1vc_pkg;
    localparam int L1VC_LINE_BITS = 256;
    localparam int L1VC_ADDR_BITS = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        GAP  = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } l1vc_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != {W{1'b1}})
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
endmodule

// File: rtl/l1_vc_requester.sv
// Services one L1 miss per miss_req assertion: optional victim writeback,
// one idle gap, then a line fill from the victim cache.
module l1_vc_requester
    import l1vc_pkg::*;
#(
    parameter int LINE_BITS = L1VC_LINE_BITS,
    parameter int ADDR_BITS = L1VC_ADDR_BITS,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 miss_req,
    input  logic                 dirty,
    input  logic [ADDR_BITS-1:0] miss_addr,
    input  logic [ADDR_BITS-1:0] victim_addr,
    input  logic [LINE_BITS-1:0] victim_line,
    output logic                 vc_read,
    output logic                 vc_write,
    output logic [ADDR_BITS-1:0] vc_addr,
    output logic [LINE_BITS-1:0] vc_wdata,
    input  logic [LINE_BITS-1:0] vc_rdata,
    input  logic                 vc_resp,
    output logic [LINE_BITS-1:0] fill_line,
    output logic                 fill_valid,
    output logic                 done,
    output logic                 busy,
    input  logic                 clr_stats,
    output logic [CNT_BITS-1:0]  miss_count,
    output logic [CNT_BITS-1:0]  wb_count
);
    l1vc_state_t          state, state_n;
    logic                 armed;
    logic                 accept;
    logic                 wb_exit;
    logic [ADDR_BITS-1:0] miss_addr_q;
    logic [ADDR_BITS-1:0] victim_addr_q;

    assign accept  = (state == IDLE) && miss_req && armed;
    assign wb_exit = (state == WB) && vc_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        vc_read  = 1'b0;
        vc_write = 1'b0;
        vc_addr  = '0;
        case (state)
            IDLE: if (accept) state_n = dirty ? WB : FILL;
            WB: begin
                vc_write = 1'b1;
                vc_addr  = victim_addr_q;
                if (vc_resp) state_n = GAP;
            end
            GAP:  state_n = FILL;
            FILL: begin
                vc_read = 1'b1;
                vc_addr = miss_addr_q;
                if (vc_resp) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // armed re-arms on any low cycle of miss_req, so a held request is served once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            armed <= 1'b1;
        else if (!miss_req)
            armed <= 1'b1;
        else if (accept)
            armed <= 1'b0;
    end

    // vc_wdata is only reloaded for dirty victims so it holds across non-WB states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            vc_wdata      <= '0;
        end else if (accept) begin
            miss_addr_q   <= miss_addr;
            victim_addr_q <= victim_addr;
            if (dirty) vc_wdata <= victim_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fill_line <= '0;
        else if (state == FILL && vc_resp)
            fill_line <= vc_rdata;
    end

    assign fill_valid = (state == DONE);
    assign done       = (state == DONE);
    assign busy       = (state != IDLE);

    sat_counter #(.W(CNT_BITS)) u_miss_cnt (
        .clk(clk), .rst_n(rst_n), .inc(accept), .clr(clr_stats), .cnt(miss_count)
    );

    sat_counter #(.W(CNT_BITS)) u_wb_cnt (
        .clk(clk), .rst_n(rst_n), .inc(wb_exit), .clr(clr_stats), .cnt(wb_count)
    );
endmodule

// File: tb/tb_l1_vc_requester.sv
// Directed + randomized bench for l1_vc_requester; a default-width and a 2-bit-counter DUT share stimulus.
module tb_l1_vc_requester;
    localparam int LB = 256;
    localparam int AB = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_req, dirty, vc_resp, clr_stats;
    logic [AB-1:0] miss_addr, victim_addr;
    logic [LB-1:0] victim_line, vc_rdata;

    logic          vc_read, vc_write, fill_valid, done, busy;
    logic [AB-1:0] vc_addr;
    logic [LB-1:0] vc_wdata, fill_line;
    logic [15:0]   miss_count, wb_count;

    logic          s_vc_read, s_vc_write, s_fill_valid, s_done, s_busy;
    logic [AB-1:0] s_vc_addr;
    logic [LB-1:0] s_vc_wdata, s_fill_line;
    logic [1:0]    s_miss_count, s_wb_count;

    int total = 0;
    int bad   = 0;
    int n_miss = 0, n_wb = 0, cyc = 0;
    logic [LB-1:0] last_wdata = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l1_vc_requester dut (
        .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .dirty(dirty),
        .miss_addr(miss_addr), .victim_addr(victim_addr), .victim_line(victim_line),
        .vc_read(vc_read), .vc_write(vc_write), .vc_addr(vc_addr), .vc_wdata(vc_wdata),
        .vc_rdata(vc_rdata), .vc_resp(vc_resp), .fill_line(fill_line),
        .fill_valid(fill_valid), .done(done), .busy(busy), .clr_stats(clr_stats),
        .miss_count(miss_count), .wb_count(wb_count)
    );

    l1_vc_requester #(.CNT_BITS(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .dirty(dirty),
        .miss_addr(miss_addr), .victim_addr(victim_addr), .victim_line(victim_line),
        .vc_read(s_vc_read), .vc_write(s_vc_write), .vc_addr(s_vc_addr), .vc_wdata(s_vc_wdata),
        .vc_rdata(vc_rdata), .vc_resp(vc_resp), .fill_line(s_fill_line),
        .fill_valid(s_fill_valid), .done(s_done), .busy(s_busy), .clr_stats(clr_stats),
        .miss_count(s_miss_count), .wb_count(s_wb_count)
    );

    function automatic logic [LB-1:0] rnd_line();
        logic [LB-1:0] r;
        for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_miss16"}, LB'(miss_count),   LB'(sat(n_miss, 16)));
        chk({tag, "_wb16"},   LB'(wb_count),     LB'(sat(n_wb, 16)));
        chk({tag, "_miss2"},  LB'(s_miss_count), LB'(sat(n_miss, 2)));
        chk({tag, "_wb2"},    LB'(s_wb_count),   LB'(sat(n_wb, 2)));
    endtask

    // Called at a negedge with the DUT idle and armed; returns at the negedge of the idle cycle after DONE.
    task automatic txn(input bit dty, input logic [AB-1:0] maddr, input logic [AB-1:0] vaddr,
                       input logic [LB-1:0] line, input logic [LB-1:0] rdata,
                       input int wb_wait, input int fill_wait, input bit clr, input bit hold);
        int acc_cyc;
        miss_req = 1'b1; dirty = dty; miss_addr = maddr; victim_addr = vaddr;
        victim_line = line; clr_stats = clr; vc_resp = 1'b0;
        @(negedge clk);
        acc_cyc = cyc;
        if (clr) begin n_miss = 0; n_wb = 0; end else n_miss++;
        clr_stats = 1'b0;
        dirty = $urandom_range(0, 1); miss_addr = $urandom; victim_addr = $urandom;
        victim_line = rnd_line();
        chk("accept_busy", LB'(busy), LB'(1));
        chk_cnt("accept");
        if (dty) begin
            for (int k = 0; k <= wb_wait; k++) begin
                if (k > 0) @(negedge clk);
                chk("wb_write", LB'(vc_write), LB'(1));
                chk("wb_read",  LB'(vc_read),  LB'(0));
                chk("wb_addr",  LB'(vc_addr),  LB'(vaddr));
                chk("wb_wdata", vc_wdata, line);
                vc_resp = (k == wb_wait);
            end
            @(negedge clk);
            n_wb++;
            last_wdata = line;
            chk("gap_write", LB'(vc_write), LB'(0));
            chk("gap_read",  LB'(vc_read),  LB'(0));
            chk("gap_addr",  LB'(vc_addr),  LB'(0));
            chk("gap_wdata", vc_wdata, line);
            chk_cnt("gap");
            vc_resp = $urandom_range(0, 1);
            @(negedge clk);
        end
        for (int k = 0; k <= fill_wait; k++) begin
            if (k > 0) @(negedge clk);
            chk("fill_read",  LB'(vc_read),  LB'(1));
            chk("fill_write", LB'(vc_write), LB'(0));
            chk("fill_addr",  LB'(vc_addr),  LB'(maddr));
            vc_resp  = (k == fill_wait);
            vc_rdata = (k == fill_wait) ? rdata : rnd_line();
        end
        @(negedge clk);
        chk("done",       LB'(done),       LB'(1));
        chk("fill_valid", LB'(fill_valid), LB'(1));
        chk("fill_line",  fill_line, rdata);
        chk("done_addr",  LB'(vc_addr), LB'(0));
        chk("latency",    LB'(cyc - acc_cyc), LB'(1 + fill_wait + (dty ? wb_wait + 2 : 0)));
        vc_resp = $urandom_range(0, 1);
        vc_rdata = rnd_line();
        miss_req = hold;
        @(negedge clk);
        chk("idle_done",  LB'(done),     LB'(0));
        chk("idle_busy",  LB'(busy),     LB'(0));
        chk("idle_rw",    LB'({vc_read, vc_write}), LB'(0));
        chk("idle_addr",  LB'(vc_addr),  LB'(0));
        chk("idle_wdata", vc_wdata, last_wdata);
        chk("idle_fill",  fill_line, rdata);
        chk_cnt("idle");
        vc_resp = 1'b0;
    endtask

    initial begin
        logic [LB-1:0] a5;
        a5 = {32{8'hA5}};
        rst_n = 1'b0; miss_req = 0; dirty = 0; vc_resp = 0; clr_stats = 0;
        miss_addr = '0; victim_addr = '0; victim_line = '0; vc_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_rw",    LB'({vc_read, vc_write}), LB'(0));
        chk("rst_flags", LB'({fill_valid, done, busy}), LB'(0));
        chk("rst_fill",  fill_line, '0);
        chk_cnt("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy0", LB'(busy), LB'(0));

        // clean miss, response on first fill cycle
        txn(1'b0, 32'h0000_1000, 32'h0, rnd_line(), a5, 0, 0, 1'b0, 1'b0);
        // dirty miss, three WB cycles
        txn(1'b1, 32'h0000_3000, 32'h0000_2000, rnd_line(), rnd_line(), 2, 1, 1'b0, 1'b0);

        // held miss_req: only one service until it drops
        txn(1'b0, 32'h0000_4000, 32'h0, rnd_line(), rnd_line(), 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            vc_resp = $urandom_range(0, 1);
            @(negedge clk);
            chk("held_busy", LB'(busy), LB'(0));
        end
        chk_cnt("held");
        miss_req = 1'b0; vc_resp = 1'b0;
        @(negedge clk);
        txn(1'b0, 32'h0000_5000, 32'h0, rnd_line(), rnd_line(), 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++)
            txn($urandom_range(0, 1), $urandom & 32'hFFFF_FFE0, $urandom & 32'hFFFF_FFE0,
                rnd_line(), rnd_line(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);

        // reset while a fill is outstanding
        miss_req = 1'b1; dirty = 1'b0; miss_addr = 32'h0000_6000;
        @(negedge clk);
        chk("rstfill_read", LB'(vc_read), LB'(1));
        rst_n = 1'b0;
        #1;
        n_miss = 0; n_wb = 0; last_wdata = '0;
        chk("rstfill_read0", LB'(vc_read), LB'(0));
        chk("rstfill_busy",  LB'(busy), LB'(0));
        chk_cnt("rstfill");
        miss_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vc_resp = 1'b1; vc_rdata = rnd_line();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstfill_nodone", LB'({done, busy}), LB'(0));
        end
        vc_resp = 1'b0;

        // saturation of the 2-bit counters, then clear racing an accept
        for (int i = 0; i < 5; i++)
            txn($urandom_range(0, 1), $urandom, $urandom, rnd_line(), rnd_line(),
                $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0);
        chk("sat_miss2", LB'(s_miss_count), LB'(3));
        txn(1'b1, 32'h0000_7000, 32'h0000_8000, rnd_line(), rnd_line(), 0, 0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l1_vc_requester.md
L1_VC_REQUESTER -- requirements
Module: l1_vc_requester

Interface
REQ-001 SHALL have parameter LINE_BITS, default 256, cache line width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 32, byte address width.
REQ-003 SHALL have parameter CNT_BITS, default 16, statistics counter width.
REQ-004 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: miss_req  in  1  L1 datapath requests line service (level).
REQ-007 SHALL have ports: dirty  in  1  victim line is dirty, sampled at accept.
REQ-008 SHALL have ports: miss_addr  in  ADDR_BITS  line-aligned address of missing line.
REQ-009 SHALL have ports: victim_addr  in  ADDR_BITS  line-aligned address of evicted line.
REQ-010 SHALL have ports: victim_line  in  LINE_BITS  evicted line data.
REQ-011 SHALL have ports: vc_read / vc_write  out  1 each  line read/write request to victim cache.
REQ-012 SHALL have ports: vc_addr  out  ADDR_BITS;  vc_wdata  out  LINE_BITS;  vc_rdata  in  LINE_BITS.
REQ-013 SHALL have ports: vc_resp  in  1  victim cache completion strobe.
REQ-014 SHALL have ports: fill_line  out  LINE_BITS  registered fill data;  fill_valid  out  1;  done  out  1;  busy  out  1.
REQ-015 SHALL have ports: clr_stats  in  1;  miss_count, wb_count  out  CNT_BITS each.

Function
REQ-016 SHALL implement FSM states IDLE, WB, GAP, FILL, DONE.
REQ-017 IDLE: accept when miss_req=1 and armed=1; latch miss_addr, victim_addr, victim_line, dirty; clear armed; next WB if dirty else FILL.
REQ-018 armed SHALL set in any cycle miss_req=0, giving one service per miss_req assertion.
REQ-019 WB: vc_write=1, vc_addr=latched victim_addr, vc_wdata=latched victim_line, held constant until vc_resp sampled 1; then GAP.
REQ-020 GAP: vc_read=vc_write=0 for exactly one cycle; then FILL.
REQ-021 FILL: vc_read=1, vc_addr=latched miss_addr, held until vc_resp sampled 1; that edge loads vc_rdata into fill_line; then DONE.
REQ-022 DONE: fill_valid=1 and done=1 for exactly one cycle; then IDLE.
REQ-023 vc_read and vc_write SHALL never be 1 together; both SHALL be Moore outputs of state.
REQ-024 vc_resp outside WB/FILL SHALL be ignored.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Latency, clean miss with resp on first request cycle: accept edge -> FILL 1 cycle -> DONE; done 2 cycles after accept cycle.
REQ-027 miss_count SHALL increment at each accept; wb_count SHALL increment on each WB exit; both saturate at all-ones.
REQ-028 clr_stats=1 SHALL zero both counters synchronously, overriding a same-cycle increment.
REQ-029 vc_addr SHALL be 0 and vc_wdata hold last value in IDLE, GAP, DONE.

Reset
REQ-030 rst_n=0 SHALL force IDLE immediately, vc_read=vc_write=0, fill_valid=done=busy=0, fill_line=0, counters=0, armed=1.
REQ-031 Reset mid-WB or mid-FILL SHALL abandon the transaction; no done pulse for it.

Structure
REQ-032 Package l1vc_pkg SHALL hold state enum l1vc_state_t and default LINE_BITS/ADDR_BITS constants.
REQ-033 Counters SHALL use one sub-module sat_counter (width parameter, inc, clr), instantiated twice.

Verification
REQ-034 Clean miss: miss_req=1, dirty=0, miss_addr=0x0000_1000, vc_resp on first FILL cycle with rdata=0xA5..A5 -> vc_write never 1, done 2 cycles after accept, fill_line=0xA5..A5, miss_count=1.
REQ-035 Dirty miss: dirty=1, victim_addr=0x0000_2000, vc_resp after 3 WB cycles -> vc_write 3 cycles at 0x2000, one GAP cycle, then vc_read at miss_addr, wb_count=1.
REQ-036 Held miss_req: miss_req kept high 10 cycles after done -> no second accept; drop 1 cycle, reassert -> second accept, miss_count=2.
REQ-037 Reset mid-FILL: rst_n=0 during FILL -> vc_read=0 same cycle, no done, counters 0.
REQ-038 Saturation: CNT_BITS=2, five misses -> miss_count=3; clr_stats with accept same cycle -> 0.
